// File: rtl/bsg_gateway_reset_seq_if.sv
// Lock/reset bundle between the gateway clock generator side and the reset sequencer.
// The slave modport is the sequencer; the master modport is whatever drives lock and software reset.
interface bsg_gateway_reset_seq_if #(
  parameter int unsigned loss_count_width_p = 8
) ();

  logic                          locked_i;
  logic                          sw_reset_i;
  logic                          io_reset_o;
  logic                          core_reset_o;
  logic                          ready_o;
  logic [loss_count_width_p-1:0] lock_loss_count_o;
  logic [1:0]                    state_o;

  modport slave (
    input  locked_i,
    input  sw_reset_i,
    output io_reset_o,
    output core_reset_o,
    output ready_o,
    output lock_loss_count_o,
    output state_o
  );

  modport master (
    output locked_i,
    output sw_reset_i,
    input  io_reset_o,
    input  core_reset_o,
    input  ready_o,
    input  lock_loss_count_o,
    input  state_o
  );

endinterface

// File: rtl/bsg_gateway_reset_seq.sv
// Gateway reset sequencer: qualifies PLL/DCM lock, releases IO reset then core reset, counts lock losses.
// Optional macro BSG_GATEWAY_RESET_SEQ_MIN_HOLD_EN enforces a min_hold_p-cycle minimum stay in S_IDLE.
module bsg_gateway_reset_seq #(
  parameter int unsigned sync_stages_p        = 2,
  parameter int unsigned lock_stable_cycles_p = 1024,
  parameter int unsigned core_delay_p         = 64,
  parameter int unsigned min_hold_p           = 16,
  parameter int unsigned loss_count_width_p   = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  bsg_gateway_reset_seq_if.slave bus_if
);

  localparam int unsigned max_ab_lp     = (lock_stable_cycles_p > core_delay_p) ?
                                          lock_stable_cycles_p : core_delay_p;
  localparam int unsigned max_cycles_lp = (max_ab_lp > min_hold_p) ? max_ab_lp : min_hold_p;
  localparam int unsigned cnt_width_lp  = $clog2(max_cycles_lp) + 1;

  localparam logic [cnt_width_lp-1:0] stable_last_lp = cnt_width_lp'(lock_stable_cycles_p - 1);
  localparam logic [cnt_width_lp-1:0] core_last_lp   = cnt_width_lp'(core_delay_p - 1);
`ifdef BSG_GATEWAY_RESET_SEQ_MIN_HOLD_EN
  localparam logic [cnt_width_lp-1:0] hold_last_lp   = cnt_width_lp'(min_hold_p - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STABLE = 2'd1,
    S_IO_REL = 2'd2,
    S_RUN    = 2'd3
  } state_e;

  logic [sync_stages_p-1:0]      sync_q, sync_d;
  logic                          locked_sync;
  state_e                        state_q, state_d;
  logic [cnt_width_lp-1:0]       cnt_q, cnt_d;
  logic [loss_count_width_p-1:0] loss_q, loss_d;
  logic                          io_reset_q, io_reset_d;
  logic                          core_reset_q, core_reset_d;
  logic                          ready_q, ready_d;
  logic                          lock_loss;

  // locked_i is asynchronous; it is only ever observed through this chain
  assign sync_d      = {sync_q[sync_stages_p-2:0], bus_if.locked_i};
  assign locked_sync = sync_q[sync_stages_p-1];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_q       <= '0;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      loss_q       <= '0;
      io_reset_q   <= 1'b1;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      loss_q       <= loss_d;
      io_reset_q   <= io_reset_d;
      core_reset_q <= core_reset_d;
      ready_q      <= ready_d;
    end
  end

  // Next-state, counter and registered-output decode
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    loss_d       = loss_q;
    lock_loss    = 1'b0;
    io_reset_d   = 1'b1;
    core_reset_d = 1'b1;
    ready_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
`ifdef BSG_GATEWAY_RESET_SEQ_MIN_HOLD_EN
        // holding cnt at 0 while sw_reset_i is high restarts the hold window on release
        if (bus_if.sw_reset_i) begin
          cnt_d = '0;
        end else if (cnt_q == hold_last_lp) begin
          if (locked_sync) state_d = S_STABLE;
        end else begin
          cnt_d = cnt_q + cnt_width_lp'(1);
        end
`else
        if (locked_sync && !bus_if.sw_reset_i) state_d = S_STABLE;
`endif
      end
      S_STABLE: begin
        if (bus_if.sw_reset_i || !locked_sync) begin
          state_d = S_IDLE;
        end else if (cnt_q == stable_last_lp) begin
          state_d = S_IO_REL;
        end else begin
          cnt_d = cnt_q + cnt_width_lp'(1);
        end
      end
      S_IO_REL: begin
        if (!locked_sync || bus_if.sw_reset_i) begin
          lock_loss = !locked_sync;
          state_d   = S_IDLE;
        end else if (cnt_q == core_last_lp) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + cnt_width_lp'(1);
        end
      end
      S_RUN: begin
        if (!locked_sync || bus_if.sw_reset_i) begin
          lock_loss = !locked_sync;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;

    if (lock_loss && (loss_q != '1)) loss_d = loss_q + loss_count_width_p'(1);

    io_reset_d   = (state_d == S_IDLE) || (state_d == S_STABLE);
    core_reset_d = (state_d != S_RUN);
    ready_d      = (state_d == S_RUN);
  end

  assign bus_if.io_reset_o        = io_reset_q;
  assign bus_if.core_reset_o      = core_reset_q;
  assign bus_if.ready_o           = ready_q;
  assign bus_if.lock_loss_count_o = loss_q;
  assign bus_if.state_o           = 2'(state_q);

`ifndef SYNTHESIS
  // Core may only run out of reset after IO, and ready mirrors core release
  a_ready_core : assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                  ready_q == !core_reset_q);
  a_order      : assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                  !core_reset_q |-> !io_reset_q);
`endif

endmodule

// File: tb/tb_bsg_gateway_reset_seq.sv
// Scoreboard bench for bsg_gateway_reset_seq: expected output-change events with their edge numbers
// are queued by the stimulus and checked by an independent monitor whenever the outputs change.
module tb_bsg_gateway_reset_seq;

  localparam int unsigned W        = 2;
  localparam int          STABLE_N = 8;
  localparam int          CORE_N   = 4;
`ifdef BSG_GATEWAY_RESET_SEQ_MIN_HOLD_EN
  localparam int          HOLD     = 16;
`else
  localparam int          HOLD     = 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int edge_no = 0;
  always @(posedge clk) edge_no <= edge_no + 1;

  bsg_gateway_reset_seq_if #(.loss_count_width_p(W)) bus ();

  bsg_gateway_reset_seq #(
    .sync_stages_p       (2),
    .lock_stable_cycles_p(STABLE_N),
    .core_delay_p        (CORE_N),
    .min_hold_p          (16),
    .loss_count_width_p  (W)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .bus_if   (bus)
  );

  typedef struct {
    int           e;
    logic [1:0]   st;
    logic         io;
    logic         core;
    logic         rdy;
    logic [W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // e < 0 means the edge stamp is not checked
  task automatic push(input int e, input logic [1:0] st, input logic [W-1:0] c);
    exp_t x;
    x.e    = e;
    x.st   = st;
    x.io   = (st == 2'd0) || (st == 2'd1);
    x.core = (st != 2'd3);
    x.rdy  = (st == 2'd3);
    x.cnt  = c;
    exp_q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int n);
    while (edge_no < n) step();
  endtask

  // S_IDLE entered (or last held by sw_reset_i) at edge ent, first edge sampling locked_i=1 at r
  task automatic enter_stable(input int ent, input int r, input logic [W-1:0] c, output int s);
    s = (r + 2 > ent + HOLD) ? r + 2 : ent + HOLD;
    push(s, 2'd1, c);
  endtask

  task automatic run_from(input int s, input logic [W-1:0] c);
    push(s + STABLE_N, 2'd2, c);
    push(s + STABLE_N + CORE_N, 2'd3, c);
    go_to(s + STABLE_N + CORE_N);
  endtask

  task automatic lose(input logic [W-1:0] c, output int e);
    bus.locked_i = 1'b0;
    e = edge_no + 3;
    push(e, 2'd0, c);
    go_to(e);
  endtask

  // Monitor: every change of the output bundle is one event checked against the queue
  logic [W+4:0] cur, prev;
  logic         seen = 1'b0;
  exp_t         got_x;

  always @(negedge clk) begin
    cur = {bus.state_o, bus.io_reset_o, bus.core_reset_o, bus.ready_o, bus.lock_loss_count_o};
    if (!seen || cur !== prev) begin
      seen  = 1'b1;
      prev  = cur;
      n_cmp = n_cmp + 1;
      if (exp_q.size() == 0) begin
        n_bad = n_bad + 1;
        $display("FAIL unexpected_event: edge=%0d st=%0d io=%0b core=%0b rdy=%0b cnt=%0d, required no change",
                 edge_no, bus.state_o, bus.io_reset_o, bus.core_reset_o, bus.ready_o,
                 bus.lock_loss_count_o);
      end else begin
        got_x = exp_q.pop_front();
        if ((got_x.e >= 0 && got_x.e != edge_no) || bus.state_o !== got_x.st ||
            bus.io_reset_o !== got_x.io || bus.core_reset_o !== got_x.core ||
            bus.ready_o !== got_x.rdy || bus.lock_loss_count_o !== got_x.cnt) begin
          n_bad = n_bad + 1;
          $display("FAIL event: got edge=%0d st=%0d io=%0b core=%0b rdy=%0b cnt=%0d, required edge=%0d st=%0d io=%0b core=%0b rdy=%0b cnt=%0d",
                   edge_no, bus.state_o, bus.io_reset_o, bus.core_reset_o, bus.ready_o,
                   bus.lock_loss_count_o, got_x.e, got_x.st, got_x.io, got_x.core, got_x.rdy,
                   got_x.cnt);
        end
      end
    end
  end

  initial begin
    int b, e, s, d;
    bus.locked_i   = 1'b0;
    bus.sw_reset_i = 1'b0;
    push(-1, 2'd0, 2'd0);
    #1 rst_n = 1'b0;
    repeat (3) step();

    // power-up with lock already present
    rst_n        = 1'b1;
    bus.locked_i = 1'b1;
    b = edge_no + 1;
    enter_stable(b - 1, b, 2'd0, s);
    run_from(s, 2'd0);

    // lock loss in S_RUN, then relock
    lose(2'd1, e);
    bus.locked_i = 1'b1;
    enter_stable(e, e + 1, 2'd1, s);
    go_to(s + 2);

    // 3-cycle lock dropout inside the stable window
    bus.locked_i = 1'b0;
    d = edge_no + 1;
    push(d + 2, 2'd0, 2'd1);
    go_to(d + 2);
    bus.locked_i = 1'b1;
    enter_stable(d + 2, d + 3, 2'd1, s);
    run_from(s, 2'd1);

    // software reset held 5 cycles in S_RUN while locked
    bus.sw_reset_i = 1'b1;
    d = edge_no + 1;
    push(d, 2'd0, 2'd1);
    go_to(d + 4);
    bus.sw_reset_i = 1'b0;
    enter_stable(d + 4, -100, 2'd1, s);
    push(s + STABLE_N, 2'd2, 2'd1);
    go_to(s + STABLE_N);

    // lock loss during S_IO_REL
    lose(2'd2, e);
    bus.locked_i = 1'b1;
    enter_stable(e, e + 1, 2'd2, s);
    run_from(s, 2'd2);

    // software reset on the same edge the lock loss is seen: one increment
    bus.locked_i = 1'b0;
    d = edge_no + 1;
    go_to(d + 1);
    bus.sw_reset_i = 1'b1;
    push(d + 2, 2'd0, 2'd3);
    go_to(d + 2);
    bus.sw_reset_i = 1'b0;
    bus.locked_i   = 1'b1;
    enter_stable(d + 2, d + 3, 2'd3, s);
    run_from(s, 2'd3);

    // two more losses: counter saturates
    lose(2'd3, e);
    bus.locked_i = 1'b1;
    enter_stable(e, e + 1, 2'd3, s);
    run_from(s, 2'd3);
    lose(2'd3, e);
    bus.locked_i = 1'b1;
    enter_stable(e, e + 1, 2'd3, s);
    push(s + STABLE_N, 2'd2, 2'd3);
    go_to(s + STABLE_N + 1);

    // asynchronous reset pulse mid-S_IO_REL, between clock edges
    push(s + STABLE_N + 1, 2'd0, 2'd0);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    b = s + STABLE_N + 2;
    enter_stable(b - 1, b, 2'd0, s);
    run_from(s, 2'd0);

    repeat (20) step();
    n_cmp = n_cmp + 1;
    if (exp_q.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL pending_events: got %0d unmatched, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
